uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Parity support is compiled in with UART_TX_PARITY_EN.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;
`endif

  function automatic int unsigned frame_bits(
    input int unsigned data_bits,
    input int unsigned stop_bits,
    input bit          parity
  );
    return 1 + data_bits + (parity ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO with synchronous reset.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD selects odd).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
`ifdef UART_TX_PARITY_EN
  parameter int PARITY_ODD = 0,
`endif
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int CPB = CLK_FREQ / BAUD;
  localparam logic [15:0] CPB_M1 = 16'(CPB - 1);
  localparam int FRAME_BITS =
    int'(frame_bits(DATA_BITS, STOP_BITS, PAR_EN));
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [15:0]          timer_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 busy_q;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign in_ready = !full;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign bit_end  = (timer_q == CPB_M1);

  // Pop when idle, or at the very end of the last stop bit.
  assign pop = !empty &&
    ((state_q == S_IDLE) ||
     (state_q == S_STOP && bit_end && bit_q == LAST_STOP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state_q != S_IDLE) || !empty;
      if (state_q != S_IDLE) begin
        timer_q <= bit_end ? '0 : timer_q + 16'd1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q <= S_START;
            shift_q <= rdata;
            tx_q    <= 1'b0;
            timer_q <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
`ifdef UART_TX_PARITY_EN
            par_q   <= shift_q[0] ^ PARITY_ODD[0];
`endif
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == LAST_DATA) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
`ifdef UART_TX_PARITY_EN
              par_q   <= par_q ^ shift_q[1];
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (bit_q != LAST_STOP) begin
              bit_q <= bit_q + 1'b1;
            end else if (pop) begin
              state_q <= S_START;
              bit_q   <= '0;
              shift_q <= rdata;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              bit_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
